trace_capture_ctrl: RTL
=======================

Name: trace_capture_ctrl

Overview:
- Sequences one trace capture: arm, wait for trace-port synchronization, wait for a pattern-match or soft trigger, gate a fixed number of trace samples into the capture FIFO, then stop.
- Sits between the register block, the trace_trigger matchers and the capture FIFO write port.
- Reports state, trigger source, sample count and error flags back for register readout.

Parameters:
- pMATCH_RULES, 8, number of pattern-match rules.
- pCOUNT_WIDTH, 16, width of the capture-length and sample counters.
- pTIMEOUT_WIDTH, 24, width of the trigger-wait timeout counter.

Ports:
- usb_clk  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- I_arm  in  1  one-cycle pulse: start a capture.
- I_abort  in  1  one-cycle pulse: stop immediately.
- I_synchronized  in  1  trace decoder is in sync.
- I_match  in  pMATCH_RULES  per-rule match pulses.
- I_pattern_trig_enable  in  pMATCH_RULES  rules allowed to trigger.
- I_soft_trig  in  1  software trigger pulse.
- I_soft_trig_enable  in  1  allow I_soft_trig.
- I_capture_len  in  pCOUNT_WIDTH  number of samples to capture.
- I_timeout  in  pTIMEOUT_WIDTH  trigger-wait limit in cycles; 0 = no timeout.
- I_sample_valid  in  1  trace datapath presents a sample.
- I_fifo_full  in  1  capture FIFO full.
- O_capture_en  out  1  FIFO write enable = CAPTURE & I_sample_valid & ~I_fifo_full.
- O_trigger  out  1  one-cycle trigger pulse.
- O_trig_rule  out  4  [3] = soft trigger; [2:0] = lowest-index matching rule.
- O_state  out  3  current state encoding.
- O_done  out  1  capture finished (level).
- O_timed_out  out  1  sticky: DONE reached through timeout.
- O_overflow  out  1  sticky: sample dropped because FIFO was full.
- O_sample_count  out  pCOUNT_WIDTH  samples written this capture.

Behaviour:
- Reset (reset_i high at the edge):
  - state = IDLE; all outputs 0.
  - Latched configuration cleared.
  - Reset overrides every other input, including mid-capture.
- States: IDLE=0, WAIT_SYNC=1, WAIT_TRIG=2, CAPTURE=3, DONE=4. Codes 5-7 return to IDLE.
- Arm:
  - Accepted in IDLE or DONE only; ignored in all other states.
  - On accept, latch I_capture_len, I_timeout, I_pattern_trig_enable and I_soft_trig_enable.
  - Clear O_done, O_timed_out, O_overflow, O_sample_count, O_trig_rule and the timeout counter.
  - Next state WAIT_SYNC.
  - Later changes to these inputs have no effect until the next arm.
- Abort:
  - Abort in any non-IDLE state goes to IDLE next cycle.
  - O_done is not set; sticky flags and counters keep their values.
  - Abort has priority over a simultaneous arm, trigger or completion.
- WAIT_SYNC: go to WAIT_TRIG on the first cycle I_synchronized = 1.
- WAIT_TRIG:
  - Trigger condition = |(I_match & latched enables) | (I_soft_trig & latched soft enable).
  - Evaluated only while registered state == WAIT_TRIG.
  - If I_synchronized = 0 and no trigger that cycle, return to WAIT_SYNC.
  - If trigger and sync loss occur in the same cycle, the trigger wins.
- Timeout:
  - Counter increments every cycle in WAIT_SYNC or WAIT_TRIG; it is not reset on WAIT_TRIG→WAIT_SYNC.
  - When the latched timeout is ≠ 0 and the counter reaches it, go to DONE with O_timed_out = 1.
  - A trigger in the same cycle beats the timeout.
- On trigger (edge that leaves WAIT_TRIG):
  - O_trigger = 1 for exactly one cycle, coincident with the first CAPTURE cycle.
  - O_trig_rule registered: bit 3 = soft trigger hit; bits [2:0] = lowest set index of masked matches (0 if none).
- CAPTURE:
  - O_capture_en is combinational as defined in Ports.
  - O_sample_count increments per capture_en cycle.
  - I_sample_valid & I_fifo_full sets O_overflow; that sample is neither written nor counted.
  - When the count reaches the latched length (the increment that makes count == len), go to DONE the next cycle. No write occurs in DONE.
  - Latched length 0: enter DONE the cycle after the trigger; O_capture_en stays 0 throughout.
  - Sync loss during CAPTURE is ignored.
- DONE: O_done = 1; hold all values until arm, abort or reset.
- O_state reflects the registered state.
- Latency: arm→WAIT_SYNC in 1 cycle; trigger condition→CAPTURE in 1 cycle.

Test Plan:
1. len=4, timeout=0, enable=0x04; arm, sync, I_match=0x04, valid held → O_trigger 1 cycle, O_trig_rule=0x2, exactly 4 capture_en pulses, O_sample_count=4, O_done=1, state=4.
2. timeout=10, no trigger, sync held → DONE after 10 wait cycles from arm+1, O_timed_out=1, O_sample_count=0.
3. len=8, FIFO full for 3 cycles mid-capture with valid held → O_overflow=1, count reaches 8 after 11 valid cycles, 8 writes total.
4. I_match=0x05 with enable=0x04 and soft trigger+enable same cycle → O_trig_rule=0xA; then sync drop in WAIT_TRIG before trigger → state returns to 1.
5. Abort in CAPTURE at count 3, then arm during CAPTURE and same cycle as abort → state IDLE, O_done=0, count stays 3; subsequent arm in IDLE clears count.
6. len=0 → DONE one cycle after trigger, zero writes; reset_i asserted mid-CAPTURE → all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl
//   Sequences a single trace capture: arm -> wait for trace sync -> wait for
//   a pattern/soft trigger -> gate a fixed number of samples into the capture
//   FIFO -> stop. Status (state, trigger source, count, sticky errors) is
//   exported for register readout.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | not armed; waiting for I_arm
//   WAIT_SYNC | armed; waiting for the trace decoder to report sync
//   WAIT_TRIG | in sync; waiting for a masked rule match or soft trigger
//   CAPTURE   | writing valid samples until the latched length is reached
//   DONE      | finished (length reached or timeout); holds until arm/abort
//
// Ports
//   usb_clk, reset_i            clock, synchronous active-high reset
//   I_arm, I_abort              one-cycle control pulses
//   I_synchronized              trace decoder sync status
//   I_match, I_pattern_trig_enable   per-rule match pulses and trigger mask
//   I_soft_trig, I_soft_trig_enable  software trigger and its enable
//   I_capture_len, I_timeout    capture length / trigger-wait limit (0 = none)
//   I_sample_valid, I_fifo_full trace datapath valid, capture FIFO full
//   O_capture_en                FIFO write enable
//   O_trigger, O_trig_rule      trigger pulse and registered trigger source
//   O_state, O_done             registered state, DONE level
//   O_timed_out, O_overflow     sticky error flags
//   O_sample_count              samples written this capture
module trace_capture_ctrl #(
  parameter int pMATCH_RULES   = 8,
  parameter int pCOUNT_WIDTH   = 16,
  parameter int pTIMEOUT_WIDTH = 24
) (
  input  logic                      usb_clk,
  input  logic                      reset_i,
  input  logic                      I_arm,
  input  logic                      I_abort,
  input  logic                      I_synchronized,
  input  logic [pMATCH_RULES-1:0]   I_match,
  input  logic [pMATCH_RULES-1:0]   I_pattern_trig_enable,
  input  logic                      I_soft_trig,
  input  logic                      I_soft_trig_enable,
  input  logic [pCOUNT_WIDTH-1:0]   I_capture_len,
  input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
  input  logic                      I_sample_valid,
  input  logic                      I_fifo_full,
  output logic                      O_capture_en,
  output logic                      O_trigger,
  output logic [3:0]                O_trig_rule,
  output logic [2:0]                O_state,
  output logic                      O_done,
  output logic                      O_timed_out,
  output logic                      O_overflow,
  output logic [pCOUNT_WIDTH-1:0]   O_sample_count
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ST_CAPTURE   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  logic [2:0]                state, state_nxt;
  logic [pCOUNT_WIDTH-1:0]   len_q;
  logic [pTIMEOUT_WIDTH-1:0] tmo_q;
  logic [pMATCH_RULES-1:0]   pat_en_q;
  logic                      soft_en_q;
  logic [pTIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [pCOUNT_WIDTH-1:0]   sample_cnt;
  logic                      trig_q;
  logic [3:0]                trig_rule_q;
  logic                      timed_out_q;
  logic                      overflow_q;

  logic [pMATCH_RULES-1:0]   masked;
  logic                      soft_hit;
  logic                      trig_hit;
  logic [2:0]                rule_idx;
  logic                      in_wait;
  logic [pTIMEOUT_WIDTH-1:0] tmo_cnt_inc;
  logic                      tmo_hit;
  logic [pCOUNT_WIDTH-1:0]   cnt_inc;
  logic                      capture_en;
  logic                      cap_last;
  logic                      arm_ok;

  assign masked      = I_match & pat_en_q;
  assign soft_hit    = I_soft_trig & soft_en_q;
  assign trig_hit    = (state == ST_WAIT_TRIG) && ((|masked) || soft_hit);
  assign in_wait     = (state == ST_WAIT_SYNC) || (state == ST_WAIT_TRIG);
  assign tmo_cnt_inc = tmo_cnt + 1'b1;
  // The counter is compared on its incremented value so a limit of N gives
  // exactly N cycles spent waiting before DONE.
  assign tmo_hit     = in_wait && (tmo_q != '0) && (tmo_cnt_inc == tmo_q);
  assign cnt_inc     = sample_cnt + 1'b1;
  // The count != len term keeps the write enable low for a zero-length capture.
  assign capture_en  = (state == ST_CAPTURE) && I_sample_valid && !I_fifo_full &&
                       (sample_cnt != len_q);
  assign cap_last    = (state == ST_CAPTURE) &&
                       ((sample_cnt == len_q) || (capture_en && (cnt_inc == len_q)));
  assign arm_ok      = I_arm && !I_abort && ((state == ST_IDLE) || (state == ST_DONE));

  // Lowest-index masked match; scan downwards so the lowest set bit wins.
  always_comb begin
    rule_idx = 3'd0;
    for (int i = pMATCH_RULES - 1; i >= 0; i--) begin
      if (masked[i]) rule_idx = i[2:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (arm_ok) state_nxt = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (I_abort)             state_nxt = ST_IDLE;
        else if (tmo_hit)        state_nxt = ST_DONE;
        else if (I_synchronized) state_nxt = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (I_abort)              state_nxt = ST_IDLE;
        else if (trig_hit)        state_nxt = ST_CAPTURE;
        else if (tmo_hit)         state_nxt = ST_DONE;
        else if (!I_synchronized) state_nxt = ST_WAIT_SYNC;
      end
      ST_CAPTURE: begin
        if (I_abort)       state_nxt = ST_IDLE;
        else if (cap_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (I_abort)     state_nxt = ST_IDLE;
        else if (arm_ok) state_nxt = ST_WAIT_SYNC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      tmo_q       <= '0;
      pat_en_q    <= '0;
      soft_en_q   <= 1'b0;
      tmo_cnt     <= '0;
      sample_cnt  <= '0;
      trig_q      <= 1'b0;
      trig_rule_q <= 4'd0;
      timed_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      trig_q <= (state == ST_WAIT_TRIG) && (state_nxt == ST_CAPTURE);

      if (arm_ok) begin
        len_q       <= I_capture_len;
        tmo_q       <= I_timeout;
        pat_en_q    <= I_pattern_trig_enable;
        soft_en_q   <= I_soft_trig_enable;
        tmo_cnt     <= '0;
        sample_cnt  <= '0;
        trig_rule_q <= 4'd0;
        timed_out_q <= 1'b0;
        overflow_q  <= 1'b0;
      end

      if (in_wait) tmo_cnt <= tmo_cnt_inc;

      if (in_wait && (state_nxt == ST_DONE)) timed_out_q <= 1'b1;

      if ((state == ST_WAIT_TRIG) && (state_nxt == ST_CAPTURE))
        trig_rule_q <= {soft_hit, rule_idx};

      // Counts every sample actually written, so the count always matches
      // the FIFO contents even if an abort lands on a write cycle.
      if (capture_en) sample_cnt <= cnt_inc;

      if ((state == ST_CAPTURE) && I_sample_valid && I_fifo_full) overflow_q <= 1'b1;
    end
  end

  assign O_capture_en   = capture_en;
  assign O_trigger      = trig_q;
  assign O_trig_rule    = trig_rule_q;
  assign O_state        = state;
  assign O_done         = (state == ST_DONE);
  assign O_timed_out    = timed_out_q;
  assign O_overflow     = overflow_q;
  assign O_sample_count = sample_cnt;

endmodule
